activation_arbiter: RTL and testbench

ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

---
 rtl/activation_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_activation_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/activation_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : activation_arbiter
//  Description : Arbitrates N_REQ requesters onto one shared, fixed-latency
//                activation unit. Each winner is served one at a time:
//                grant -> launch -> wait LATENCY -> return result.
//                Arbitration is round-robin by default. Define the macro
//                ACT_FIXED_PRIORITY_EN to select fixed priority instead,
//                where the lowest asserted index wins.
//  Revision    : 1.0  initial release
// ============================================================================
module activation_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 8,
    parameter int LATENCY = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         act_in,
    output logic                      act_start,
    input  logic [OUT_W-1:0]          act_out,
    output logic [OUT_W-1:0]          res_data,
    output logic [N_REQ-1:0]          res_valid,
    output logic                      busy
);

    localparam int              c_IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              c_CNT_W  = 8;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(LATENCY - 1);
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   c_ONE    = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [c_IDX_W-1:0]  r_owner,      w_owner_nxt;
    logic [c_CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic [N_REQ-1:0]    r_gnt,        w_gnt_nxt;
    logic [DATA_W-1:0]   r_act_in,     w_act_in_nxt;
    logic                r_act_start,  w_act_start_nxt;
    logic [OUT_W-1:0]    r_res_data,   w_res_data_nxt;
    logic [N_REQ-1:0]    r_res_valid,  w_res_valid_nxt;
    logic [c_IDX_W-1:0]  w_pick;

    // Per-requester view of the packed operand bus.
    logic [DATA_W-1:0]   w_opnd [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_opnd[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef ACT_FIXED_PRIORITY_EN
    // Fixed priority: lowest asserted index wins (scan high to low, last hit kept).
    always_comb begin
        w_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_pick = c_IDX_W'(k);
            end
        end
    end
`else
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W:0]    w_sum [N_REQ];
    logic [c_IDX_W-1:0]  w_idx [N_REQ];

    // Rotated search order: candidate k is (ptr + k) mod N_REQ.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            w_sum[k] = {1'b0, r_ptr} + (c_IDX_W + 1)'(k);
            if (w_sum[k] >= (c_IDX_W + 1)'(N_REQ)) begin
                w_sum[k] = w_sum[k] - (c_IDX_W + 1)'(N_REQ);
            end
            w_idx[k] = w_sum[k][c_IDX_W-1:0];
        end
    end

    // Round-robin: first asserted request at or after the pointer, wrapping.
    always_comb begin
        w_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[w_idx[k]]) begin
                w_pick = w_idx[k];
            end
        end
    end

    // Pointer moves just past the owner when its result is returned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (r_state == S_RETURN) begin
            r_ptr <= (r_owner == c_LAST) ? '0 : r_owner + 1'b1;
        end
    end
`endif

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
        w_act_in_nxt    = r_act_in;
        w_res_data_nxt  = r_res_data;
        w_gnt_nxt       = '0;
        w_act_start_nxt = 1'b0;
        w_res_valid_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_owner_nxt  = w_pick;
                    w_act_in_nxt = w_opnd[w_pick];
                    w_gnt_nxt    = c_ONE << w_pick;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_act_start_nxt = 1'b1;
                w_cnt_nxt       = '0;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAT_M1) begin
                    w_state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                w_res_data_nxt  = act_out;
                w_res_valid_nxt = c_ONE << r_owner;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_act_in    <= '0;
            r_act_start <= 1'b0;
            r_res_data  <= '0;
            r_res_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_act_in    <= w_act_in_nxt;
            r_act_start <= w_act_start_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign act_in    = r_act_in;
    assign act_start = r_act_start;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_activation_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_activation_arbiter
//  Description : Randomised scoreboard bench for activation_arbiter. The
//                stimulus process also runs a transaction-level reference
//                model and queues the expected grant, launch and result
//                events. A monitor pops the queues and compares them
//                whenever the DUT presents an output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_activation_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 16;
    localparam int OUT_W     = 8;
    localparam int LATENCY   = 16;
    localparam int MAXE      = 4000;
    localparam int RAND_END  = 2500;
    localparam int DIR_START = 2600;
    localparam int RAND2_END = 3400;
    localparam int LAST_E    = 3500;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         gnt;
    logic [DATA_W-1:0]        act_in;
    logic                     act_start;
    logic [OUT_W-1:0]         act_out;
    logic [OUT_W-1:0]         res_data;
    logic [N_REQ-1:0]         res_valid;
    logic                     busy;

    activation_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .act_in    (act_in),
        .act_start (act_start),
        .act_out   (act_out),
        .res_data  (res_data),
        .res_valid (res_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0]  vec;
        logic [DATA_W-1:0] opnd;
        int                cyc;
    } exp_t;

    exp_t             qg[$];
    exp_t             qs[$];
    exp_t             qr[$];
    logic [OUT_W-1:0] actv  [0:MAXE];
    bit               busyv [0:MAXE];
    bit               rstv  [0:MAXE];
    int               e_cur  = 0;
    int               n_chk  = 0;
    int               n_fail = 0;
    bit               done   = 1'b0;

    task automatic check(input bit ok, input string nm, input longint act, input longint expv);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, e_cur, act, expv);
        end
    endtask

    function automatic int arb_rr(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int arb_fp(input logic [N_REQ-1:0] r);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // Stimulus plus reference model: drives inputs for edge e, predicts its effect.
    initial begin
        bit               pend [N_REQ];
        logic [DATA_W-1:0] opd [N_REQ];
        logic [N_REQ-1:0] rq;
        int               m_ptr, m_free, drop, g_dir, rst_e, w;
        bit               rnd_new, in_dir;
        exp_t             x;
        m_ptr = 0; m_free = 0; drop = -1; g_dir = -1; rst_e = -1;
        for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b0; opd[i] = '0; end
        reset = 1'b0; req = '0; req_data = '0; act_out = '0;
        for (int e = 1; e <= LAST_E; e++) begin
            @(negedge clk);
            e_cur   = e;
            in_dir  = (g_dir >= 0) && (e <= rst_e);
            rnd_new = (e > 3 && e <= RAND_END) || (rst_e > 0 && e > rst_e + 1 && e <= RAND2_END);
            if (drop >= 0) begin
                pend[drop] = 1'b0;
                opd[drop]  = in_dir ? 16'hFFFF : DATA_W'($urandom);
                drop = -1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i]) begin
                    if (!in_dir) opd[i] = DATA_W'($urandom);
                    if (rnd_new && $urandom_range(0, 5) == 0) pend[i] = 1'b1;
                end else if (rnd_new && $urandom_range(0, 40) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (e == DIR_START) begin
                for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
                pend[1] = 1'b1;
                opd[1]  = 16'h0040;
            end
            if (g_dir >= 0 && e == g_dir + 3) pend[2] = 1'b1;
            if (g_dir >= 0 && e == g_dir + 6) pend[2] = 1'b0;
            if (rst_e > 0 && e == rst_e + 1) begin
                for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b1; opd[i] = DATA_W'($urandom); end
            end
            for (int i = 0; i < N_REQ; i++) begin
                rq[i] = pend[i];
                req_data[i*DATA_W +: DATA_W] = opd[i];
            end
            reset   = !(e <= 3 || e == rst_e);
            req     = rq;
            act_out = OUT_W'($urandom);
            actv[e] = act_out;
            rstv[e] = !reset;
            if (!reset) begin
                qg.delete(); qs.delete(); qr.delete();
                m_ptr  = 0;
                m_free = e + 1;
                for (int j = e; j <= MAXE && j < e + LATENCY + 4; j++) busyv[j] = 1'b0;
            end else if (e >= m_free && rq != '0) begin
`ifdef ACT_FIXED_PRIORITY_EN
                w = arb_fp(rq);
`else
                w = arb_rr(rq, m_ptr);
`endif
                x.vec = N_REQ'(1) << w; x.opnd = opd[w];
                x.cyc = e;               qg.push_back(x);
                x.cyc = e + 1;           qs.push_back(x);
                x.cyc = e + LATENCY + 2; qr.push_back(x);
                for (int j = e; j <= e + LATENCY + 1 && j <= MAXE; j++) busyv[j] = 1'b1;
                m_free = e + LATENCY + 3;
                m_ptr  = (w + 1) % N_REQ;
                drop   = w;
                if (e >= DIR_START && g_dir < 0) begin
                    g_dir = e;
                    rst_e = e + 7;
                end
            end
        end
        @(posedge clk);
        #2;
        done = 1'b1;
        check(qg.size() + qs.size() + qr.size() == 0, "pending_expectations",
              qg.size() + qs.size() + qr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Monitor: pops expectations whenever the DUT presents gnt, act_start or res_valid.
    always @(posedge clk) begin
        int   ec;
        exp_t x;
        #1;
        if (!done && e_cur > 0) begin
            ec = e_cur;
            check(busy == busyv[ec], "busy", busy, busyv[ec]);
            if (rstv[ec]) begin
                check(act_in == '0,   "reset_act_in",   act_in,   0);
                check(res_data == '0, "reset_res_data", res_data, 0);
            end
            if (gnt != '0 || (qg.size() > 0 && qg[0].cyc <= ec)) begin
                if (qg.size() == 0) begin
                    check(gnt == '0, "gnt_unexpected", gnt, 0);
                end else begin
                    x = qg.pop_front();
                    check(x.cyc == ec,  "gnt_cycle", ec,  x.cyc);
                    check(gnt == x.vec, "gnt_vec",   gnt, x.vec);
                end
            end
            if (act_start || (qs.size() > 0 && qs[0].cyc <= ec)) begin
                if (qs.size() == 0) begin
                    check(act_start == 1'b0, "act_start_unexpected", act_start, 0);
                end else begin
                    x = qs.pop_front();
                    check(x.cyc == ec,      "act_start_cycle", ec,        x.cyc);
                    check(act_start == 1'b1, "act_start",      act_start, 1);
                    check(act_in == x.opnd, "act_in_launch",   act_in,    x.opnd);
                end
            end
            if (res_valid != '0 || (qr.size() > 0 && qr[0].cyc <= ec)) begin
                if (qr.size() == 0) begin
                    check(res_valid == '0, "res_valid_unexpected", res_valid, 0);
                end else begin
                    x = qr.pop_front();
                    check(x.cyc == ec,            "res_cycle",     ec,        x.cyc);
                    check(res_valid == x.vec,     "res_valid_vec", res_valid, x.vec);
                    check(res_data == actv[x.cyc], "res_data",     res_data,  actv[x.cyc]);
                    check(act_in == x.opnd,       "act_in_held",   act_in,    x.opnd);
                end
            end
        end
    end

endmodule
`default_nettype wire
